// File: rtl/ins_arbiter.sv
// ============================================================================
// Module   : ins_arbiter
// Purpose  : Four-requester round-robin arbiter that turns granted channel
//            writes into 16-bit instruction words for the channel decoder,
//            with a programmable idle gap after every issued write.
// Options  : ARB_SHADOW_EN - keep a per-channel shadow of the last written
//            value and drop (ack without strobe) writes that repeat it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_arbiter #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [7:0]  req_ch,
  input  logic [47:0] req_data,
  output logic [3:0]  ack,
  output logic [15:0] ins,
  output logic        ins_we,
  output logic        busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;

  localparam logic [3:0] c_GAP_LOAD = 4'(GAP_CYCLES);

  logic [1:0]  r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_grant;
  logic [3:0]  r_gap_cnt;

  logic [1:0]  w_grant;
  logic [1:0]  w_idx;
  logic [1:0]  w_ch;
  logic [11:0] w_data;
  logic        w_hit;
  logic        r_skip;

  // Round-robin search: walk from ptr+3 down to ptr so the closest
  // requester at or above ptr is the last (winning) assignment.
  always_comb begin
    w_grant = r_ptr;
    w_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) begin
        w_grant = w_idx;
      end
    end
  end

  assign w_ch   = req_ch[{w_grant, 1'b0} +: 2];
  assign w_data = req_data[w_grant * 12 +: 12];
  assign busy   = (r_state != c_IDLE);

`ifdef ARB_SHADOW_EN
  logic [11:0] r_shadow [4];
  logic [3:0]  r_valid;

  assign w_hit = r_valid[w_ch] && (r_shadow[w_ch] == w_data);

  // Track the last value written to each channel; remember whether the
  // current grant is a redundant write so ISSUE can skip the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 4'b0000;
      r_skip  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= 12'h000;
      end
    end else if (r_state == c_IDLE && |req) begin
      r_skip <= w_hit;
      if (!w_hit) begin
        r_shadow[w_ch] <= w_data;
        r_valid[w_ch]  <= 1'b1;
      end
    end
  end
`else
  assign w_hit  = 1'b0;
  assign r_skip = 1'b0;
`endif

  // Arbitration FSM: sample in IDLE, pulse ack/strobe for one ISSUE cycle,
  // then hold off new requests for the configured number of gap cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_ptr     <= 2'd0;
      r_grant   <= 2'd0;
      r_gap_cnt <= 4'd0;
      ack       <= 4'b0000;
      ins_we    <= 1'b0;
      ins       <= 16'h0000;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (|req) begin
            r_state <= c_ISSUE;
            r_grant <= w_grant;
            ack     <= 4'b0001 << w_grant;
            if (!w_hit) begin
              ins    <= {2'b00, w_ch, w_data};
              ins_we <= 1'b1;
            end
          end
        end
        c_ISSUE: begin
          ack    <= 4'b0000;
          ins_we <= 1'b0;
          r_ptr  <= r_grant + 2'd1;
          if (r_skip || c_GAP_LOAD == 4'd0) begin
            r_state <= c_IDLE;
          end else begin
            r_state   <= c_GAP;
            r_gap_cnt <= c_GAP_LOAD;
          end
        end
        c_GAP: begin
          if (r_gap_cnt <= 4'd1) begin
            r_state   <= c_IDLE;
            r_gap_cnt <= 4'd0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
